logic_op_queue: RTL and testbench

Operand issue queue that sits directly upstream of `logic_unit` in the ALU datapath. It accepts logic instructions over a valid/ready handshake and decodes the 6-bit function field into the 3-bit `logic_unit` opcode. It buffers up to DEPTH decoded operations in a circular FIFO and presents the oldest one, with its A/B operands, to `logic_unit`. It also flags unsupported function codes and keeps a saturating count of them.

---
 rtl/logic_op_queue.sv | 133 +++++++++++++
 tb/tb_logic_op_queue.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/logic_op_queue.sv
// logic_op_queue: operand issue queue feeding logic_unit.
// Accepts logic instructions on a valid/ready handshake, decodes the 6-bit
// funct into a 3-bit logic_unit opcode at push time, and buffers up to DEPTH
// decoded entries in a circular FIFO. The oldest entry is presented on out_*.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   in_valid/in_ready   producer handshake; in_ready = (count < DEPTH)
//   in_funct, in_a/b    instruction funct and operands
//   out_valid/out_ready consumer handshake; out_valid = (count != 0)
//   out_opcode, out_a/b decoded head entry (all zero while empty)
//   out_illegal         head entry carried an unsupported funct
//   count               occupancy 0..DEPTH
//   illegal_count       saturating count of accepted illegal functs
module logic_op_queue #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [5:0]                 in_funct,
  input  logic [WIDTH-1:0]           in_a,
  input  logic [WIDTH-1:0]           in_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2:0]                 out_opcode,
  output logic [WIDTH-1:0]           out_a,
  output logic [WIDTH-1:0]           out_b,
  output logic                       out_illegal,
  output logic [$clog2(DEPTH):0]     count,
  output logic [7:0]                 illegal_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [7:0]       illegal_count_q, illegal_count_d;

  // Storage is intentionally left unreset; out_* are masked while empty.
  logic [2:0]       opcode_mem  [DEPTH];
  logic             illegal_mem [DEPTH];
  logic [WIDTH-1:0] a_mem       [DEPTH];
  logic [WIDTH-1:0] b_mem       [DEPTH];

  logic       push, pop;
  logic [2:0] dec_opcode;
  logic       dec_illegal;

  // Handshake status comes from registered count only, so no comb path
  // from in_* or out_ready reaches an output.
  assign in_ready  = (count_q < CntW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    dec_opcode  = 3'b000;
    dec_illegal = 1'b0;
    unique case (in_funct)
      6'h24:   dec_opcode = 3'b000;
      6'h25:   dec_opcode = 3'b001;
      6'h26:   dec_opcode = 3'b010;
      6'h27:   dec_opcode = 3'b011;
      default: dec_illegal = 1'b1;
    endcase
  end

  always_comb begin
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    count_d         = count_q;
    illegal_count_d = illegal_count_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (dec_illegal && (illegal_count_q != 8'hFF)) begin
        illegal_count_d = illegal_count_q + 8'd1;
      end
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      illegal_count_q <= '0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      illegal_count_q <= illegal_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      opcode_mem[wr_ptr_q]  <= dec_opcode;
      illegal_mem[wr_ptr_q] <= dec_illegal;
      a_mem[wr_ptr_q]       <= in_a;
      b_mem[wr_ptr_q]       <= in_b;
    end
  end

  always_comb begin
    out_opcode  = 3'b000;
    out_a       = '0;
    out_b       = '0;
    out_illegal = 1'b0;
    if (out_valid) begin
      out_opcode  = opcode_mem[rd_ptr_q];
      out_a       = a_mem[rd_ptr_q];
      out_b       = b_mem[rd_ptr_q];
      out_illegal = illegal_mem[rd_ptr_q];
    end
  end

  assign count         = count_q;
  assign illegal_count = illegal_count_q;

endmodule

// File: tb/tb_logic_op_queue.sv
module tb_logic_op_queue;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_funct;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_opcode;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic        out_illegal;
  logic [1:0]  count;
  logic [7:0]  illegal_count;

  int n_checks = 0;
  int n_errors = 0;

  logic_op_queue #(
    .WIDTH(32),
    .DEPTH(2)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_funct     (in_funct),
    .in_a         (in_a),
    .in_b         (in_b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_opcode   (out_opcode),
    .out_a        (out_a),
    .out_b        (out_b),
    .out_illegal  (out_illegal),
    .count        (count),
    .illegal_count(illegal_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] f, input logic [31:0] a,
                       input logic [31:0] b);
    in_valid = v;
    in_funct = f;
    in_a     = a;
    in_b     = b;
  endtask

  initial begin
    reset     = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 6'h00, 32'h0, 32'h0);
    step();
    step();
    reset = 1'b0;

    // Reset state
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_opcode", out_opcode, 0);
    check("rst_a", out_a, 0);
    check("rst_b", out_b, 0);
    check("rst_illegal", out_illegal, 0);
    check("rst_count", count, 0);
    check("rst_illcnt", illegal_count, 0);

    // Single push of OR
    drive(1'b1, 6'h25, 32'hF0F0_0000, 32'h0000_0F0F);
    step();
    drive(1'b0, 6'h00, 32'h0, 32'h0);
    check("one_valid", out_valid, 1);
    check("one_opcode", out_opcode, 3'b001);
    check("one_a", out_a, 32'hF0F0_0000);
    check("one_b", out_b, 32'h0000_0F0F);
    check("one_count", count, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("pop_valid", out_valid, 0);
    check("pop_opcode", out_opcode, 0);
    check("pop_a", out_a, 0);
    check("pop_b", out_b, 0);
    check("pop_count", count, 0);

    // Fill, stall, wrap
    drive(1'b1, 6'h24, 32'h11, 32'h22);
    step();
    drive(1'b1, 6'h26, 32'h33, 32'h44);
    step();
    check("full_count", count, 2);
    check("full_ready", in_ready, 0);
    drive(1'b1, 6'h27, 32'h55, 32'h66);
    step();
    check("stall_count", count, 2);
    check("stall_head", out_opcode, 3'b000);
    check("stall_head_a", out_a, 32'h11);
    drive(1'b0, 6'h00, 32'h0, 32'h0);
    out_ready = 1'b1;
    check("pop_cycle_ready", in_ready, 0);
    step();
    out_ready = 1'b0;
    check("after_pop_ready", in_ready, 1);
    check("after_pop_count", count, 1);
    check("after_pop_head", out_opcode, 3'b010);
    drive(1'b1, 6'h27, 32'h77, 32'h88);
    step();
    drive(1'b0, 6'h00, 32'h0, 32'h0);
    check("wrap_count", count, 2);
    check("wrap_head", out_opcode, 3'b010);
    out_ready = 1'b1;
    step();
    check("wrap_pop1_op", out_opcode, 3'b011);
    check("wrap_pop1_a", out_a, 32'h77);
    step();
    out_ready = 1'b0;
    check("wrap_empty", out_valid, 0);
    check("wrap_count0", count, 0);

    // Streaming with out_ready high
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 6'(6'h24 + i), 32'(i), 32'(i + 10));
      step();
      check("stream_op", out_opcode, 32'(i));
      check("stream_count", count, 1);
      check("stream_a", out_a, 32'(i));
    end
    drive(1'b0, 6'h00, 32'h0, 32'h0);
    step();
    out_ready = 1'b0;
    check("stream_end_count", count, 0);

    // Illegal funct
    drive(1'b1, 6'h20, 32'hAA, 32'hBB);
    step();
    drive(1'b0, 6'h00, 32'h0, 32'h0);
    check("ill_flag", out_illegal, 1);
    check("ill_opcode", out_opcode, 0);
    check("ill_cnt1", illegal_count, 1);
    check("ill_valid", out_valid, 1);
    out_ready = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      drive(1'b1, 6'h3F, 32'(i), 32'h0);
      step();
      if (i == 253) check("ill_cnt254", illegal_count, 254);
      if (i == 254) check("ill_cnt255", illegal_count, 255);
    end
    check("ill_sat", illegal_count, 255);
    check("ill_stream_count", count, 1);
    drive(1'b0, 6'h00, 32'h0, 32'h0);
    step();
    out_ready = 1'b0;
    check("ill_drain_count", count, 0);
    check("ill_pop_keeps", illegal_count, 255);

    // Simultaneous push and pop at count=1
    drive(1'b1, 6'h24, 32'h1, 32'h0);
    step();
    check("pp_pre_count", count, 1);
    drive(1'b1, 6'h26, 32'h2, 32'h0);
    out_ready = 1'b1;
    step();
    drive(1'b0, 6'h00, 32'h0, 32'h0);
    out_ready = 1'b0;
    check("pp_count", count, 1);
    check("pp_head_op", out_opcode, 3'b010);
    check("pp_head_a", out_a, 32'h2);
    drive(1'b1, 6'h25, 32'h3, 32'h0);
    step();
    check("mr_pre_count", count, 2);

    // Mid-operation reset with push and pop requested
    reset     = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 6'h27, 32'h99, 32'h0);
    step();
    reset     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 6'h00, 32'h0, 32'h0);
    check("mr_count", count, 0);
    check("mr_valid", out_valid, 0);
    check("mr_ready", in_ready, 1);
    check("mr_illcnt", illegal_count, 0);
    check("mr_opcode", out_opcode, 0);
    step();
    check("mr_not_queued", count, 0);
    check("mr_still_empty", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
